// File: rtl/ghost_path_planner.sv
// Per tick, scans the 4 neighbours of each ghost through an RD_LAT map port and commits the best legal step.
// Sweep is 4*NUM_GHOSTS*(RD_LAT+1) cycles + 1 commit; no backpressure, wrdone advances positions in any state.
module ghost_path_planner #(
  parameter int NUM_GHOSTS = 4,
  parameter int X_W        = 6,
  parameter int Y_W        = 5,
  parameter int VAL_W      = 8,
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30,
  parameter int RD_LAT     = 1,
  parameter int WALL_VAL   = 255,
  parameter int DELAY      = 50000000,
  parameter int START_X    = 16,
  parameter int START_Y    = 13
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic                      map_ready,
  input  logic                      wrdone,
  output logic [X_W-1:0]            rd_x,
  output logic [Y_W-1:0]            rd_y,
  input  logic [VAL_W-1:0]          rd_val,
  output logic [NUM_GHOSTS*X_W-1:0] curr_x,
  output logic [NUM_GHOSTS*Y_W-1:0] curr_y,
  output logic [NUM_GHOSTS*X_W-1:0] next_x,
  output logic [NUM_GHOSTS*Y_W-1:0] next_y,
  output logic                      busy,
  output logic                      plan_valid
);

  localparam int GI_W = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
  localparam int PH_W = $clog2(RD_LAT + 1);
  localparam int TC_W = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int DW   = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int SC_W = (VAL_W > DW) ? VAL_W : DW;

  localparam logic [X_W-1:0]   X_MAX   = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX   = Y_W'(GRID_H - 1);
  localparam logic [VAL_W-1:0] WALL    = VAL_W'(WALL_VAL);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(RD_LAT);
  localparam logic [GI_W-1:0]  G_LAST  = GI_W'(NUM_GHOSTS - 1);
  localparam logic [TC_W-1:0]  TC_LAST = TC_W'(DELAY - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, HOLD} state_t;

  state_t state, state_nx;

  logic [X_W-1:0]  cur_x [NUM_GHOSTS];
  logic [Y_W-1:0]  cur_y [NUM_GHOSTS];
  logic [X_W-1:0]  prv_x [NUM_GHOSTS];
  logic [Y_W-1:0]  prv_y [NUM_GHOSTS];
  logic [X_W-1:0]  nxt_x [NUM_GHOSTS];
  logic [Y_W-1:0]  nxt_y [NUM_GHOSTS];
  logic [X_W-1:0]  pln_x [NUM_GHOSTS];
  logic [Y_W-1:0]  pln_y [NUM_GHOSTS];

  logic [GI_W-1:0] gidx;
  logic [1:0]      cand;
  logic [PH_W-1:0] phase;
  logic [TC_W-1:0] tick;
  logic [1:0]      mode_l;
  logic [X_W-1:0]  base_x, pbase_x, best_x, cx, kx, dx, nb_x;
  logic [Y_W-1:0]  base_y, pbase_y, best_y, cy, ky, dy, nb_y;
  logic [SC_W-1:0] best_score, score, nb_score;
  logic [VAL_W-1:0] inv_val;
  logic [1:0]      csel;
  logic            best_vld, rev_ok, offg, cand_ok, is_prev, take, nb_vld, nrev_ok;
  logic            sample, last_cand, last_ghost;

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_pack
    assign curr_x[g*X_W +: X_W] = cur_x[g];
    assign curr_y[g*Y_W +: Y_W] = cur_y[g];
    assign next_x[g*X_W +: X_W] = nxt_x[g];
    assign next_y[g*Y_W +: Y_W] = nxt_y[g];
  end

  assign sample     = (state == SCAN) && (phase == PH_LAST);
  assign last_cand  = sample && (cand == 2'd3);
  assign last_ghost = (gidx == G_LAST);
  assign csel       = 2'(gidx);

  // Candidate cell for the current slot; off-grid slots are flagged rather than wrapped.
  always_comb begin
    cx   = base_x;
    cy   = base_y;
    offg = 1'b0;
    case (cand)
      2'd0:    begin cy = base_y - Y_W'(1); offg = (base_y == '0);    end
      2'd1:    begin cy = base_y + Y_W'(1); offg = (base_y == Y_MAX); end
      2'd2:    begin cx = base_x - X_W'(1); offg = (base_x == '0);    end
      default: begin cx = base_x + X_W'(1); offg = (base_x == X_MAX); end
    endcase
  end

  // All modes reduce to "smallest score wins": frightened inverts the map value.
  always_comb begin
    kx      = csel[0] ? X_MAX : '0;
    ky      = csel[1] ? Y_MAX : '0;
    dx      = (cx >= kx) ? cx - kx : kx - cx;
    dy      = (cy >= ky) ? cy - ky : ky - cy;
    inv_val = ~rd_val;
    case (mode_l)
      2'd1:    score = SC_W'(dx) + SC_W'(dy);
      2'd2:    score = SC_W'(inv_val);
      default: score = SC_W'(rd_val);
    endcase
  end

  // Reverse move is tracked separately and only used when nothing else is legal.
  always_comb begin
    cand_ok  = !offg && (rd_val != WALL);
    is_prev  = (cx == pbase_x) && (cy == pbase_y);
    take     = cand_ok && !is_prev && (!best_vld || (score < best_score));
    nb_vld   = best_vld || (cand_ok && !is_prev);
    nb_score = take ? score : best_score;
    nb_x     = take ? cx : best_x;
    nb_y     = take ? cy : best_y;
    nrev_ok  = rev_ok || (cand_ok && is_prev);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable && map_ready) state_nx = SCAN;
      SCAN:    if (last_cand && last_ghost) state_nx = COMMIT;
      COMMIT:  state_nx = HOLD;
      HOLD:    if (tick == TC_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SCAN) || (state == COMMIT);
    rd_x = '0;
    rd_y = '0;
    if ((state == SCAN) && !offg) begin
      rd_x = cx;
      rd_y = cy;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int g = 0; g < NUM_GHOSTS; g++) begin
        cur_x[g] <= X_W'(START_X + 7 * g);
        cur_y[g] <= Y_W'(START_Y);
        prv_x[g] <= X_W'(START_X + 7 * g);
        prv_y[g] <= Y_W'(START_Y);
        nxt_x[g] <= X_W'(START_X + 7 * g);
        nxt_y[g] <= Y_W'(START_Y);
        pln_x[g] <= X_W'(START_X + 7 * g);
        pln_y[g] <= Y_W'(START_Y);
      end
      gidx       <= '0;
      cand       <= '0;
      phase      <= '0;
      tick       <= '0;
      mode_l     <= '0;
      base_x     <= '0;
      base_y     <= '0;
      pbase_x    <= '0;
      pbase_y    <= '0;
      best_x     <= '0;
      best_y     <= '0;
      best_score <= '0;
      best_vld   <= 1'b0;
      rev_ok     <= 1'b0;
      plan_valid <= 1'b0;
    end else begin
      plan_valid <= 1'b0;
      if (wrdone) begin
        for (int g = 0; g < NUM_GHOSTS; g++) begin
          prv_x[g] <= cur_x[g];
          prv_y[g] <= cur_y[g];
          cur_x[g] <= nxt_x[g];
          cur_y[g] <= nxt_y[g];
        end
      end
      case (state)
        IDLE: begin
          if (enable && map_ready) begin
            mode_l   <= mode;
            gidx     <= '0;
            cand     <= '0;
            phase    <= '0;
            base_x   <= cur_x[0];
            base_y   <= cur_y[0];
            pbase_x  <= prv_x[0];
            pbase_y  <= prv_y[0];
            best_vld <= 1'b0;
            rev_ok   <= 1'b0;
          end
        end
        SCAN: begin
          if (sample) begin
            phase      <= '0;
            cand       <= cand + 2'd1;
            best_vld   <= nb_vld;
            best_score <= nb_score;
            best_x     <= nb_x;
            best_y     <= nb_y;
            rev_ok     <= nrev_ok;
            if (cand == 2'd3) begin
              pln_x[gidx] <= nb_vld ? nb_x : (nrev_ok ? pbase_x : base_x);
              pln_y[gidx] <= nb_vld ? nb_y : (nrev_ok ? pbase_y : base_y);
              best_vld    <= 1'b0;
              rev_ok      <= 1'b0;
              if (!last_ghost) begin
                gidx    <= gidx + GI_W'(1);
                base_x  <= cur_x[gidx + GI_W'(1)];
                base_y  <= cur_y[gidx + GI_W'(1)];
                pbase_x <= prv_x[gidx + GI_W'(1)];
                pbase_y <= prv_y[gidx + GI_W'(1)];
              end
            end
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        COMMIT: begin
          for (int g = 0; g < NUM_GHOSTS; g++) begin
            nxt_x[g] <= pln_x[g];
            nxt_y[g] <= pln_y[g];
          end
          plan_valid <= 1'b1;
          tick       <= '0;
        end
        default: tick <= tick + TC_W'(1);
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_path_planner.sv
// Randomised and directed sweeps of ghost_path_planner against a candidate-list reference model.
`timescale 1ns/1ps
module tb_ghost_path_planner;
  localparam int NG    = 4;
  localparam int XW    = 6;
  localparam int YW    = 5;
  localparam int GW    = 40;
  localparam int GH    = 30;
  localparam int RL    = 1;
  localparam int WALLV = 255;
  localparam int DLY   = 4;
  localparam int SWEEP = 4 * NG * (RL + 1);
  localparam int SLOT  = 4 * (RL + 1);
  localparam int LIMIT = 200;

  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1, enable = 1'b0, map_ready = 1'b0, wrdone = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic [7:0] rd_val;
  logic [NG*XW-1:0] curr_x, next_x;
  logic [NG*YW-1:0] curr_y, next_y;
  logic busy, plan_valid;

  ghost_path_planner #(.DELAY(DLY)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .mode(mode),
    .map_ready(map_ready), .wrdone(wrdone), .rd_x(rd_x), .rd_y(rd_y),
    .rd_val(rd_val), .curr_x(curr_x), .curr_y(curr_y), .next_x(next_x),
    .next_y(next_y), .busy(busy), .plan_valid(plan_valid)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  logic [7:0] mem [64][32];
  int bad_rd = 0;
  always @(posedge CLOCK_50) begin
    rd_val <= mem[rd_x][rd_y];
    if (rd_x == 6'd63 || rd_y == 5'd31) bad_rd <= bad_rd + 1;
  end

  int n_chk = 0, n_pass = 0;
  int m_cx[NG], m_cy[NG], m_px[NG], m_py[NG], m_nx[NG], m_ny[NG];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int gcx(input int g); return int'(curr_x[g*XW +: XW]); endfunction
  function automatic int gcy(input int g); return int'(curr_y[g*YW +: YW]); endfunction
  function automatic int gnx(input int g); return int'(next_x[g*XW +: XW]); endfunction
  function automatic int gny(input int g); return int'(next_y[g*YW +: YW]); endfunction

  // Reference: list the four neighbours, keep on-grid non-walls, drop the reverse move if
  // anything else remains, then take the first lowest score.
  function automatic void plan_one(input int g, input int cx, input int cy, input int px,
                                   input int py, input int md, output int ox, output int oy);
    int kx[4], ky[4];
    bit ok[4];
    int nvalid, best, bs, sc, ex, ey, dx, dy;
    kx = '{cx, cx, cx - 1, cx + 1};
    ky = '{cy - 1, cy + 1, cy, cy};
    ex = (g % 2) ? GW - 1 : 0;
    ey = ((g / 2) % 2) ? GH - 1 : 0;
    nvalid = 0;
    for (int i = 0; i < 4; i++) begin
      ok[i] = 1'b0;
      if (kx[i] >= 0 && kx[i] < GW && ky[i] >= 0 && ky[i] < GH)
        ok[i] = (mem[kx[i]][ky[i]] != 8'(WALLV));
      if (ok[i]) nvalid++;
    end
    if (nvalid > 1)
      for (int i = 0; i < 4; i++) if (kx[i] == px && ky[i] == py) ok[i] = 1'b0;
    best = -1;
    bs = 0;
    for (int i = 0; i < 4; i++) begin
      if (ok[i]) begin
        dx = kx[i] - ex; dy = ky[i] - ey;
        if (md == 1)      sc = (dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy);
        else if (md == 2) sc = 255 - int'(mem[kx[i]][ky[i]]);
        else              sc = int'(mem[kx[i]][ky[i]]);
        if (best < 0 || sc < bs) begin best = i; bs = sc; end
      end
    end
    ox = (best < 0) ? cx : kx[best];
    oy = (best < 0) ? cy : ky[best];
  endfunction

  task automatic model_reset();
    for (int g = 0; g < NG; g++) begin
      m_cx[g] = 16 + 7 * g; m_cy[g] = 13;
      m_px[g] = m_cx[g];    m_py[g] = 13;
      m_nx[g] = m_cx[g];    m_ny[g] = 13;
    end
  endtask

  task automatic model_wr();
    for (int g = 0; g < NG; g++) begin
      m_px[g] = m_cx[g]; m_py[g] = m_cy[g];
      m_cx[g] = m_nx[g]; m_cy[g] = m_ny[g];
    end
  endtask

  task automatic check_pos(input string tag);
    for (int g = 0; g < NG; g++) begin
      chk($sformatf("%s_curr_x%0d", tag, g), gcx(g), m_cx[g]);
      chk($sformatf("%s_curr_y%0d", tag, g), gcy(g), m_cy[g]);
      chk($sformatf("%s_next_x%0d", tag, g), gnx(g), m_nx[g]);
      chk($sformatf("%s_next_y%0d", tag, g), gny(g), m_ny[g]);
    end
  endtask

  // kind 0: flat 100, 1: flat 10, 2: random values with ~15% walls
  task automatic fill_map(input int kind);
    for (int x = 0; x < 64; x++)
      for (int y = 0; y < 32; y++) begin
        if (x >= GW || y >= GH)  mem[x][y] = 8'd0;
        else if (kind == 0)      mem[x][y] = 8'd100;
        else if (kind == 1)      mem[x][y] = 8'd10;
        else if ($urandom_range(0, 99) < 15) mem[x][y] = 8'(WALLV);
        else                     mem[x][y] = 8'($urandom_range(0, 254));
      end
  endtask

  // wr_at: edge index after sweep start at which wrdone is sampled (0 = none).
  task automatic run_sweep(input int md, input int wr_at, input bit wr_after);
    int ex[NG], ey[NG];
    int n;
    for (int g = 0; g < NG; g++) begin
      if (wr_at > 0 && wr_at < g * SLOT)
        plan_one(g, m_nx[g], m_ny[g], m_cx[g], m_cy[g], md, ex[g], ey[g]);
      else
        plan_one(g, m_cx[g], m_cy[g], m_px[g], m_py[g], md, ex[g], ey[g]);
    end
    @(negedge CLOCK_50);
    mode = 2'(md); enable = 1'b1; map_ready = 1'b1;
    @(posedge CLOCK_50); #1;
    enable = 1'b0;
    n = 0;
    while (n < LIMIT) begin
      wrdone = (wr_at == n + 1);
      @(posedge CLOCK_50); #1;
      n++;
      wrdone = 1'b0;
      if (n == 1) chk("busy_in_scan", busy, 1);
      if (plan_valid) break;
    end
    chk("plan_latency", n, SWEEP + 1);
    chk("busy_in_hold", busy, 0);
    if (wr_at > 0) model_wr();
    for (int g = 0; g < NG; g++) begin m_nx[g] = ex[g]; m_ny[g] = ey[g]; end
    check_pos("plan");
    @(posedge CLOCK_50); #1;
    chk("plan_valid_pulse", plan_valid, 0);
    if (wr_after) begin
      wrdone = 1'b1;
      @(posedge CLOCK_50); #1;
      wrdone = 1'b0;
      model_wr();
      check_pos("wr");
    end
    repeat (DLY + 3) @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    int k, sel, pv_cnt;
    fill_map(0);
    model_reset();
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_pos("reset");
    chk("reset_busy", busy, 0);
    chk("reset_pv", plan_valid, 0);
    chk("reset_rd_x", rd_x, 0);
    chk("reset_rd_y", rd_y, 0);
    @(negedge CLOCK_50) reset = 1'b0;

    mem[16][12] = 8'd5; mem[16][14] = 8'd3; mem[15][13] = 8'd3; mem[17][13] = 8'd9;
    run_sweep(0, 0, 0);
    chk("chase_tie_x", gnx(0), 16); chk("chase_tie_y", gny(0), 14);
    run_sweep(2, 0, 0);
    chk("fright_x", gnx(0), 17); chk("fright_y", gny(0), 13);
    mem[17][13] = 8'(WALLV);
    run_sweep(2, 0, 0);
    chk("fright_wall_x", gnx(0), 16); chk("fright_wall_y", gny(0), 12);

    mem[17][13] = 8'd9; mem[15][13] = 8'd0;
    run_sweep(0, 0, 1);
    chk("step_left_x", gcx(0), 15);
    mem[15][12] = 8'(WALLV); mem[15][14] = 8'(WALLV); mem[14][13] = 8'(WALLV);
    run_sweep(0, 0, 1);
    chk("only_rev_x", gcx(0), 16); chk("only_rev_y", gcy(0), 13);
    mem[16][12] = 8'd9; mem[16][14] = 8'd9; mem[17][13] = 8'd9; mem[15][13] = 8'd1;
    run_sweep(0, 0, 0);
    chk("no_rev_x", gnx(0), 16); chk("no_rev_y", gny(0), 12);
    mem[16][12] = 8'(WALLV); mem[16][14] = 8'(WALLV); mem[17][13] = 8'(WALLV);
    run_sweep(0, 0, 0);
    chk("rev_fallback_x", gnx(0), 15); chk("rev_fallback_y", gny(0), 13);
    run_sweep(0, SWEEP + 1, 0);
    chk("commit_wr_curr_x", gcx(0), 15);

    // Reset during SCAN
    @(negedge CLOCK_50);
    enable = 1'b1; map_ready = 1'b1;
    @(posedge CLOCK_50); #1;
    enable = 1'b0;
    repeat (10) @(posedge CLOCK_50);
    @(negedge CLOCK_50) reset = 1'b1;
    @(posedge CLOCK_50); #1;
    model_reset();
    chk("midreset_busy", busy, 0);
    chk("midreset_rd_x", rd_x, 0);
    check_pos("midreset");
    @(negedge CLOCK_50) reset = 1'b0;
    pv_cnt = 0;
    for (int i = 0; i < SWEEP + 10; i++) begin
      @(posedge CLOCK_50); #1;
      if (plan_valid) pv_cnt++;
    end
    chk("midreset_no_plan", pv_cnt, 0);

    fill_map(1);
    for (int s = 0; s < 36; s++) run_sweep(1, 0, 1);
    chk("scatter_corner0_x", gcx(0) <= 1, 1);

    for (int s = 0; s < 30; s++) begin
      fill_map(2);
      sel = $urandom_range(0, 3);
      k = 0;
      if (sel == 2) k = SWEEP + 1;
      if (sel == 3) begin
        k = $urandom_range(1, SWEEP - 1);
        while (k % SLOT == 0) k = $urandom_range(1, SWEEP - 1);
      end
      run_sweep($urandom_range(0, 3), k, sel == 1);
    end

    chk("no_wrapped_read", bad_rd, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
